alarm_ring_controller: RTL

ALARM_RING_CONTROLLER -- requirements
Module: alarm_ring_controller

---
 rtl/alarm_ring_controller.sv | 118 +++++++++++
 1 files changed

// File: rtl/alarm_ring_controller.sv
// Alarm ring sequencer: detects the alarm-time match edge, rings, snoozes a
// limited number of times and holds dismissed until the matching minute ends.
module alarm_ring_controller #(
  parameter int SNOOZE_SECS = 540,
  parameter int RING_SECS   = 60,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       SEC_TICK,
  input  logic [3:0] TIME_HRS,
  input  logic [5:0] TIME_MINS,
  input  logic       TIME_AM_PM,
  input  logic [3:0] ALARM_HRS,
  input  logic [5:0] ALARM_MINS,
  input  logic       ALARM_AM_PM,
  input  logic       ALARM_ON,
  input  logic       SNOOZE,
  input  logic       STOP,
  output logic       BUZZER,
  output logic       SNOOZE_ACTIVE,
  output logic [1:0] SNOOZE_CNT,
  output logic [1:0] RING_STATE
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RINGING   = 2'd1,
    SNOOZING  = 2'd2,
    DISMISSED = 2'd3
  } state_t;

  localparam logic [6:0] RING_LIM = 7'(RING_SECS);
  localparam logic [9:0] SNZ_LOAD = 10'(SNOOZE_SECS);
  localparam logic [1:0] SNZ_MAX  = 2'(MAX_SNOOZE);

  state_t     state;
  logic       match, match_d;
  logic [6:0] ring_cnt;
  logic [9:0] snz_cnt;
  logic [1:0] snz_used;

  assign match = ALARM_ON &&
                 ({TIME_AM_PM, TIME_HRS, TIME_MINS} == {ALARM_AM_PM, ALARM_HRS, ALARM_MINS});

  // Outputs are decoded from the state register, so they trail it by one edge.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state         <= IDLE;
      match_d       <= 1'b0;
      ring_cnt      <= '0;
      snz_cnt       <= '0;
      snz_used      <= '0;
      BUZZER        <= 1'b0;
      SNOOZE_ACTIVE <= 1'b0;
      SNOOZE_CNT    <= '0;
      RING_STATE    <= '0;
    end else begin
      match_d       <= match;
      BUZZER        <= (state == RINGING);
      SNOOZE_ACTIVE <= (state == SNOOZING);
      SNOOZE_CNT    <= snz_used;
      RING_STATE    <= state;
      case (state)
        IDLE: begin
          ring_cnt <= '0;
          snz_cnt  <= '0;
          snz_used <= '0;
          if (match && !match_d) state <= RINGING;
        end
        RINGING: begin
          if (!ALARM_ON) begin
            state    <= IDLE;
            ring_cnt <= '0;
            snz_cnt  <= '0;
            snz_used <= '0;
          end else if (STOP) begin
            state <= DISMISSED;
          end else if (SNOOZE && (snz_used < SNZ_MAX)) begin
            state    <= SNOOZING;
            snz_cnt  <= SNZ_LOAD;
            snz_used <= snz_used + 2'd1;
          end else if (SEC_TICK && (ring_cnt != RING_LIM)) begin
            ring_cnt <= ring_cnt + 7'd1;
            if (ring_cnt + 7'd1 == RING_LIM) state <= DISMISSED;
          end
        end
        SNOOZING: begin
          if (!ALARM_ON) begin
            state    <= IDLE;
            ring_cnt <= '0;
            snz_cnt  <= '0;
            snz_used <= '0;
          end else if (STOP) begin
            state <= DISMISSED;
          end else if (SEC_TICK && (snz_cnt != 10'd0)) begin
            snz_cnt <= snz_cnt - 10'd1;
            if (snz_cnt == 10'd1) begin
              state    <= RINGING;
              ring_cnt <= '0;
            end
          end
        end
        DISMISSED: begin
          // Hold until the matching minute passes so the same minute cannot re-trigger.
          if (!match) begin
            state    <= IDLE;
            ring_cnt <= '0;
            snz_cnt  <= '0;
            snz_used <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
